led_switch_io: RTL

LED_SWITCH_IO -- requirements
Module: led_switch_io

---
 rtl/led_switch_io.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/led_switch_io.sv
// Memory-mapped LED output register and debounced switch input port.
// Switch changes are accepted only after DEB_CYCLES stable synchronized cycles.
module led_switch_io #(
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W      = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        LEDCtrl,
    input  logic        SwitchCtrl,
    input  logic        ioWrite,
    input  logic        ioRead,
    input  logic [3:0]  addr_in,
    input  logic [31:0] write_data,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out,
    output logic [15:0] io_rdata
);

    typedef enum logic {
        STABLE,
        COUNTING
    } deb_state_t;

    localparam logic [3:0]       OFS_HALF   = 4'h0;
    localparam logic [3:0]       OFS_HIGH   = 4'h2;
    localparam logic [3:0]       OFS_STATUS = 4'h4;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    deb_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [15:0]      sync1, sync2;
    logic [15:0]      cand, cand_d;
    logic [15:0]      sw_db, sw_db_d;
    logic             sw_chg, sw_chg_d;
    logic             accept;
    logic             status_read;

    // The decoder drives a full word; only the low halfword reaches the LEDs.
    logic unused_write_bits;
    assign unused_write_bits = ^write_data[31:16];

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out <= '0;
        end else if (LEDCtrl && ioWrite) begin
            case (addr_in)
                OFS_HALF: led_out       <= write_data[15:0];
                OFS_HIGH: led_out[15:8] <= write_data[7:0];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switch_in;
            sync2 <= sync1;
        end
    end

    assign status_read = SwitchCtrl && ioRead && (addr_in == OFS_STATUS);

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cand_d  = cand;
        sw_db_d = sw_db;
        accept  = 1'b0;
        case (state)
            STABLE: begin
                cnt_d = '0;
                if (sync2 != sw_db) begin
                    state_d = COUNTING;
                    cnt_d   = CNT_ONE;
                    cand_d  = sync2;
                end
            end
            COUNTING: begin
                if (sync2 != cand) begin
                    if (sync2 == sw_db) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else begin
                        cand_d = sync2;
                        cnt_d  = CNT_ONE;
                    end
                end else if (cnt >= CNT_LAST) begin
                    sw_db_d = cand;
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            default: state_d = STABLE;
        endcase

        // A new acceptance outranks a read-clear on the same edge.
        sw_chg_d = sw_chg;
        if (accept) begin
            sw_chg_d = 1'b1;
        end else if (status_read) begin
            sw_chg_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= STABLE;
            cnt    <= '0;
            cand   <= '0;
            sw_db  <= '0;
            sw_chg <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            cand   <= cand_d;
            sw_db  <= sw_db_d;
            sw_chg <= sw_chg_d;
        end
    end

    always_comb begin
        io_rdata = '0;
        if (SwitchCtrl && ioRead) begin
            case (addr_in)
                OFS_HALF:   io_rdata = sw_db;
                OFS_HIGH:   io_rdata = {8'h00, sw_db[15:8]};
                OFS_STATUS: io_rdata = {15'b0, sw_chg};
                default:    io_rdata = '0;
            endcase
        end
    end

endmodule
